// File: rtl/lsu_mem_stage.sv
// Load/store memory stage: one word-wide bus transaction per operation, with
// load alignment/extension and misaligned/illegal-op exception reporting.
`timescale 1ns/1ps

module lsu_mem_stage #(
   parameter int XLEN = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [3:0]        req_op,
   input  logic [XLEN-1:0]   req_addr,
   input  logic [XLEN-1:0]   req_wdata,
   input  logic [4:0]        req_rd,
   output logic              mem_req,
   output logic              mem_we,
   output logic [XLEN-1:0]   mem_addr,
   output logic [3:0]        mem_be,
   output logic [XLEN-1:0]   mem_wdata,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [XLEN-1:0]   mem_rdata,
   output logic              wb_valid,
   output logic [4:0]        wb_rd,
   output logic [XLEN-1:0]   wb_data,
   output logic              done,
   output logic              exc_valid,
   output logic [3:0]        exc_cause,
   output logic [XLEN-1:0]   exc_addr
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

   state_t            state, next_state;
   logic [3:0]        op_q;
   logic [XLEN-1:0]   addr_q;
   logic [XLEN-1:0]   wdata_q;
   logic [4:0]        rd_q;
   logic              exc_q;
   logic [3:0]        cause_q;
   logic [XLEN-1:0]   ldata_q;

   logic              op_legal;
   logic              misaligned;
   logic              in_exc;
   logic [3:0]        in_cause;
   logic [XLEN-1:0]   rdata_shifted;
   logic [7:0]        byte_sel;
   logic [15:0]       half_sel;
   logic [XLEN-1:0]   load_ext;

   // op[1:0] is the access size, op[2] selects zero-extension, op[3] marks a store
   always_comb begin
      op_legal = 1'b0;
      case (req_op)
         4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd8, 4'd9, 4'd10: op_legal = 1'b1;
         default: op_legal = 1'b0;
      endcase
      misaligned = ((req_op[1:0] == 2'd1) && req_addr[0]) ||
                   ((req_op[1:0] == 2'd2) && (req_addr[1:0] != 2'b00));
      in_exc     = !op_legal || misaligned;
      if (!op_legal)
         in_cause = 4'd2;
      else if (req_op[3])
         in_cause = 4'd6;
      else
         in_cause = 4'd4;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: if (req_valid) next_state = in_exc ? RESP : REQ;
         REQ:  if (mem_gnt) next_state = op_q[3] ? RESP : WAIT;
         WAIT: if (mem_rvalid) next_state = RESP;
         RESP: next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         op_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rd_q    <= '0;
         exc_q   <= 1'b0;
         cause_q <= '0;
         ldata_q <= '0;
      end else begin
         state <= next_state;
         if (state == IDLE && req_valid) begin
            op_q    <= req_op;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            rd_q    <= req_rd;
            exc_q   <= in_exc;
            cause_q <= in_cause;
         end
         if (state == WAIT && mem_rvalid)
            ldata_q <= load_ext;
      end
   end

   // Lane extraction from the returned word using the latched byte offset
   always_comb begin
      rdata_shifted = mem_rdata >> {addr_q[1:0], 3'b000};
      byte_sel      = rdata_shifted[7:0];
      half_sel      = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (op_q[2:0])
         3'd0:    load_ext = {{24{byte_sel[7]}}, byte_sel};
         3'd1:    load_ext = {{16{half_sel[15]}}, half_sel};
         3'd4:    load_ext = {24'd0, byte_sel};
         3'd5:    load_ext = {16'd0, half_sel};
         default: load_ext = mem_rdata;
      endcase
   end

   // Bus outputs are only non-zero while a request is outstanding
   always_comb begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_be    = 4'b0000;
      mem_wdata = '0;
      if (state == REQ) begin
         mem_req  = 1'b1;
         mem_we   = op_q[3];
         mem_addr = {addr_q[XLEN-1:2], 2'b00};
         case (op_q[1:0])
            2'd0: begin
               mem_be    = 4'b0001 << addr_q[1:0];
               mem_wdata = {4{wdata_q[7:0]}};
            end
            2'd1: begin
               mem_be    = 4'b0011 << addr_q[1:0];
               mem_wdata = {2{wdata_q[15:0]}};
            end
            default: begin
               mem_be    = 4'b1111;
               mem_wdata = wdata_q;
            end
         endcase
      end
   end

   // Retirement pulses; rd=0 loads retire without a register write
   always_comb begin
      req_ready = (state == IDLE) && rst_n;
      done      = (state == RESP);
      wb_valid  = 1'b0;
      wb_rd     = '0;
      wb_data   = '0;
      exc_valid = 1'b0;
      exc_cause = '0;
      exc_addr  = '0;
      if (state == RESP) begin
         if (exc_q) begin
            exc_valid = 1'b1;
            exc_cause = cause_q;
            exc_addr  = (cause_q == 4'd2) ? '0 : addr_q;
         end else if (!op_q[3] && (rd_q != 5'd0)) begin
            wb_valid = 1'b1;
            wb_rd    = rd_q;
            wb_data  = ldata_q;
         end
      end
   end

endmodule
